// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
//
// Shared definitions for the S/R flip-flop front end and its benches.
//
//   DEFAULT_DEBOUNCE  default number of consecutive mismatching synchronised
//                     samples before a debounced level flips
//   PRIO_DROP         simultaneous set/reset edges: emit neither command
//   PRIO_SET          simultaneous set/reset edges: set command wins
//   PRIO_RESET        simultaneous set/reset edges: reset command wins
//   cmd_t             one cycle's worth of command outputs (s, r, conflict)
//   arbitrate()       maps the two edge flags plus policy onto a cmd_t
// ---------------------------------------------------------------------------
package sr_pkg;

    localparam int DEFAULT_DEBOUNCE = 4;

    localparam int PRIO_DROP  = 0;
    localparam int PRIO_SET   = 1;
    localparam int PRIO_RESET = 2;

    typedef struct packed {
        logic s;
        logic r;
        logic conflict;
    } cmd_t;

    // The downstream latch must never see s=r=1, so a simultaneous request
    // is always collapsed to at most one command. An out-of-range policy
    // behaves like PRIO_DROP, which is the safe choice.
    function automatic cmd_t arbitrate(input logic set_rise,
                                       input logic reset_rise,
                                       input int   prio);
        cmd_t cmd;
        cmd = '0;
        unique case ({set_rise, reset_rise})
            2'b10: cmd.s = 1'b1;
            2'b01: cmd.r = 1'b1;
            2'b11: begin
                cmd.conflict = 1'b1;
                if (prio == PRIO_SET) begin
                    cmd.s = 1'b1;
                end else if (prio == PRIO_RESET) begin
                    cmd.r = 1'b1;
                end
            end
            default: cmd = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// ---------------------------------------------------------------------------
// sr_debounce
//
// One pushbutton channel: two-flop synchroniser, debounce counter, stable
// level and rising-edge flag.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive synchronised cycles the input must differ
//                    from the stable level before the level flips (1..65535)
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   btn_raw   in   raw asynchronous button input
//   level     out  debounced (stable) level
//   rise      out  high for the one cycle after the stable level rises
// ---------------------------------------------------------------------------
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;

    // The counter tracks how many consecutive cycles the synchronised input
    // has disagreed with the stable level. Any agreement restarts the count,
    // so a bounce shorter than DEBOUNCE_CYCLES never moves the level. The
    // flip happens on the edge where the count would reach DEBOUNCE_CYCLES;
    // the counter clears there instead, so it never needs to hold that value
    // and can never wrap.
    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        cnt_d         = '0;

        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // All channel state, synchroniser included, clears on reset so that a
    // button held across reset release is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
        end
    end

    assign level = stable_q;
    assign rise  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen
//
// Turns two raw pushbuttons into single-cycle set/reset commands for the S/R
// flip-flop stage. Each button is synchronised, debounced and rising-edge
// detected; simultaneous edges are arbitrated so s and r are never both high.
//
// Parameters
//   DEBOUNCE_CYCLES  debounce length per channel (1..65535)
//   PRIORITY         simultaneous-edge policy: PRIO_DROP / PRIO_SET /
//                    PRIO_RESET (0 / 1 / 2)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   btn_set    in   raw asynchronous set button
//   btn_reset  in   raw asynchronous reset button
//   s          out  one-cycle set command
//   r          out  one-cycle reset command
//   conflict   out  one-cycle flag: both debounced edges in the same cycle
//   set_lvl    out  debounced level of btn_set
//   reset_lvl  out  debounced level of btn_reset
// ---------------------------------------------------------------------------
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int PRIORITY        = PRIO_DROP
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic s,
    output logic r,
    output logic conflict,
    output logic set_lvl,
    output logic reset_lvl
);

    logic set_rise;
    logic reset_rise;

    cmd_t cmd_q, cmd_d;

    sr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_set),
        .level   (set_lvl),
        .rise    (set_rise)
    );

    sr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_reset_db (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_reset),
        .level   (reset_lvl),
        .rise    (reset_rise)
    );

    // Edge flags are already one cycle wide, so registering the arbitrated
    // result gives one-cycle commands. Edges in different cycles pass
    // straight through independently; only exact coincidence is arbitrated.
    always_comb begin
        cmd_d = '0;
        cmd_d = arbitrate(set_rise, reset_rise, PRIORITY);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign s        = cmd_q.s;
    assign r        = cmd_q.r;
    assign conflict = cmd_q.conflict;

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Front-end command generator that drives the S/R flip-flop stage from two raw, asynchronous pushbutton inputs. Each input is synchronised, debounced and rising-edge detected, yielding single-cycle set/reset command pulses. Simultaneous requests are arbitrated so the illegal s=r=1 code is never presented downstream.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its stable level before the stable level changes; legal range 1..65535.
PRIORITY, 0, simultaneous-edge policy: 0 = drop both, 1 = set wins, 2 = reset wins; other values illegal.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset_n  input  1  synchronous, active-low reset
btn_set  input  1  raw asynchronous set request, active high
btn_reset  input  1  raw asynchronous reset request, active high
s  output  1  one-cycle set command to the flip-flop stage
r  output  1  one-cycle reset command to the flip-flop stage
conflict  output  1  one-cycle flag: both debounced edges occurred in the same cycle
set_lvl  output  1  debounced level of btn_set
reset_lvl  output  1  debounced level of btn_reset

Behaviour:
- Reset: one clk, synchronous, active-low, as decided. When reset_n=0 at a rising edge, clear all synchroniser flops, counters, stable levels, edge-history flops and outputs. After that edge: s=0, r=0, conflict=0, set_lvl=0, reset_lvl=0.
- Reset mid-debounce discards the partial count. No pulse is emitted for any activity sampled while reset_n=0.
- Per channel, identical for set and reset:
  - 2-flop synchroniser, sync1 then sync2, both reset to 0.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync2 equals the stable level, the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - The counter never wraps.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles leaves the stable level unchanged.
  - The edge flag is stable & ~stable_prev. stable_prev is registered.
- Latency (N = DEBOUNCE_CYCLES): let e0 be the edge that first samples the new raw level into sync1.
  - set_lvl / reset_lvl update at edge e0+N+1.
  - s / r assert for exactly one cycle after edge e0+N+2.
- Falling edges of the debounced levels produce no command.
- A button held through reset release produces exactly one pulse, N+2 edges after the first edge with reset_n=1.
- Arbitration is registered in the same stage as the pulse outputs:
  - Only the set edge flag → s=1.
  - Only the reset edge flag → r=1.
  - Both flags in the same cycle → conflict=1, plus PRIORITY 0: s=r=0; PRIORITY 1: s=1, r=0; PRIORITY 2: s=0, r=1.
  - Edges in different cycles are never merged or delayed, even one cycle apart.
- Invariant: s&r is 0 in every cycle. s, r and conflict are never high for two consecutive cycles from a single press.

Decomposition:
- Shared package sr_pkg:
  - PRIO_DROP=0, PRIO_SET=1, PRIO_RESET=2 constants.
  - Default debounce constant.
  - Also used by the flip-flop stage's bench.
- One natural sub-module, sr_debounce: synchroniser, counter, stable level and edge flag, parameterised by DEBOUNCE_CYCLES. It is instantiated twice.
- Arbitration and output registers stay in sr_cmd_gen.

Test Plan:
1. N=4, PRIORITY=0, reset_n=0 for 2 cycles, then btn_set rises and is held → set_lvl=1 after e0+5; s=1 for exactly 1 cycle after e0+6; r=0 and conflict=0 throughout.
2. N=4, btn_reset glitch high for 3 cycles, then low; later held 4+ cycles → no r pulse for the glitch; exactly one r pulse for the held press, at e0+6 of that press.
3. N=4, btn_set and btn_reset rise on the same edge, separate runs with PRIORITY=0/1/2 → conflict=1 for 1 cycle in every run; (s,r) = (0,0), (1,0), (0,1) respectively.
4. btn_reset rises one cycle after btn_set, N=4, PRIORITY=0 → s pulse at e0+6, r pulse at e0+7, conflict never asserted.
5. btn_set held high, reset_n pulled low mid-count (2 cycles into debounce) for 1 cycle, then released with btn_set still high → no pulse before release; outputs 0 during reset; one s pulse 6 edges after release.
6. Randomised bouncing on both inputs for 10k cycles, N=1 and N=8 → s&r never 1; each command pulse is preceded by ≥N stable synchronised cycles; pulse count matches a reference-model count.
